// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with 4-word lines.
// Optional hit/miss statistics are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_data_o,
  input  logic [127:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [127:0]     data_arr [LINES];

  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;

  logic [1:0]       cpu_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic             hit;
  logic             hit_acc;
  logic             miss_det;
  logic             refill;
  logic             stall_int;
  logic [1:0]       unused_addr;

  assign cpu_off     = cpu_addr_i[3:2];
  assign cpu_idx     = cpu_addr_i[4+IDX_W-1:4];
  assign cpu_tag     = cpu_addr_i[31:4+IDX_W];
  assign unused_addr = cpu_addr_i[1:0];

  assign hit      = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
  assign hit_acc  = (state == IDLE) && cpu_req_i && hit;
  assign miss_det = (state == IDLE) && cpu_req_i && !hit;
  assign refill   = (state == ALLOCATE) && mem_ack_i;

  assign cpu_data_o = data_arr[cpu_idx][{cpu_off, 5'b0} +: 32];

  // Stall is forced low while reset is held, even if a request is still presented.
  assign cpu_stall_o = stall_int & rst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nxt;
      if (refill) begin
        valid[lat_idx] <= 1'b1;
        dirty[lat_idx] <= 1'b0;
      end
      if (hit_acc && cpu_we_i) begin
        dirty[cpu_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (miss_det) begin
      lat_tag <= cpu_tag;
      lat_idx <= cpu_idx;
    end
    if (refill) begin
      data_arr[lat_idx] <= mem_data_i;
      tag_arr[lat_idx]  <= lat_tag;
    end
    if (hit_acc && cpu_we_i) begin
      data_arr[cpu_idx][{cpu_off, 5'b0} +: 32] <= cpu_data_i;
    end
  end

  always_comb begin
    state_nxt  = state;
    stall_int  = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    case (state)
      IDLE: begin
        if (miss_det) begin
          stall_int = 1'b1;
          state_nxt = (valid[cpu_idx] && dirty[cpu_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        stall_int  = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_arr[lat_idx], lat_idx, 4'b0};
        mem_data_o = data_arr[lat_idx];
        if (mem_ack_i) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        stall_int  = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {lat_tag, lat_idx, 4'b0};
        if (mem_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        replay;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // The hit that replays a refilled access is not a fresh hit and is not counted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      replay   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      replay <= refill;
      if (hit_acc && !replay && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 32'd1;
      if (miss_det && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: scoreboarded CPU loads and a queued memory responder.
module tb_dcache_ctrl;

  localparam int LAT = 3;
  localparam logic [127:0] LINE_A  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] LINE_AW = 128'h4444_4444_DEAD_BEEF_2222_2222_1111_1111;
  localparam logic [127:0] LINE_B  = 128'hBBBB_0003_BBBB_0002_BBBB_0001_BBBB_0000;
  localparam logic [127:0] LINE_C  = 128'hCCCC_0003_CCCC_0002_CCCC_0001_CCCC_0000;
  localparam logic [127:0] LINE_D  = 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000;

  logic         clk;
  logic         rst_n;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wline;
    logic [127:0] rline;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] rd_q[$];

  dcache_ctrl #(.LINES(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_wdata),
    .cpu_data_o (cpu_rdata),
    .cpu_stall_o(cpu_stall),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata),
    .mem_ack_i  (mem_ack),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks each request LAT cycles after the first cycle it is seen.
  initial begin
    int    cnt;
    mreq_t cur;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    cur       = '{we: 1'b0, addr: 32'h0, wline: 128'h0, rline: 128'h0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          cnt     = 0;
        end
        if (mem_req) begin
          cnt++;
          if (cnt == 1) begin
            checks++;
            if (mem_q.size() == 0) begin
              errors++;
              $display("FAIL mem_unexpected_req: got we=%0b addr=%h, required no request", mem_we, mem_addr);
            end else begin
              cur = mem_q.pop_front();
              if (mem_we !== cur.we || mem_addr !== cur.addr ||
                  (cur.we && mem_wdata !== cur.wline)) begin
                errors++;
                $display("FAIL mem_req: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                         mem_we, mem_addr, mem_wdata, cur.we, cur.addr, cur.wline);
              end
            end
          end
          if (cnt == LAT + 1) begin
            mem_ack   = 1'b1;
            mem_rdata = cur.rline;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int exp_stall, input string name);
    int          stalls;
    logic [31:0] exp;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (!we) rd_q.push_back(exp_data);
    stalls = 0;
    #1;
    while (cpu_stall && stalls < 60) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (stalls !== exp_stall) begin
      errors++;
      $display("FAIL %s_stall: got %0d stall cycles, required %0d", name, stalls, exp_stall);
    end
    if (!we) begin
      exp = rd_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL %s_data: got %h, required %h", name, cpu_rdata, exp);
      end
    end
    if (exp_stall == 0) begin
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL %s_hit_memreq: got mem_req=%0b, required 0", name, mem_req);
      end
    end
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic check_mem_q_empty(input string name);
    checks++;
    if (mem_q.size() != 0) begin
      errors++;
      $display("FAIL %s_memq: got %0d pending requests, required 0", name, mem_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL %s: got stall=%0b req=%0b we=%0b addr=%h data=%h, required all 0",
               name, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++;
      $display("FAIL %s_cnt: got hit=%0d miss=%0d, required 0 0", name, hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_miss();
    mem_q.push_back('{we: 1'b0, addr: 32'h40, wline: 128'h0, rline: LINE_A});
    access(1'b0, 32'h40, 32'h0, 32'h1111_1111, 2 + LAT, "clean_miss");
    check_mem_q_empty("clean_miss");
  endtask

  task automatic test_hit();
    access(1'b0, 32'h44, 32'h0, 32'h2222_2222, 0, "load_hit");
  endtask

  task automatic test_store_load();
    access(1'b1, 32'h48, 32'hDEAD_BEEF, 32'h0, 0, "store_hit");
    access(1'b0, 32'h48, 32'h0, 32'hDEAD_BEEF, 0, "load_after_store");
  endtask

  task automatic test_dirty_miss();
    mem_q.push_back('{we: 1'b1, addr: 32'h40, wline: LINE_AW, rline: 128'h0});
    mem_q.push_back('{we: 1'b0, addr: 32'h140, wline: 128'h0, rline: LINE_B});
    access(1'b0, 32'h148, 32'h0, 32'hBBBB_0002, 1 + 2 * (LAT + 1), "dirty_miss");
    check_mem_q_empty("dirty_miss");
  endtask

  task automatic test_stats();
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
`ifdef DCACHE_STATS_EN
    exp_hit  = 32'd3;
    exp_miss = 32'd2;
`else
    exp_hit  = 32'd0;
    exp_miss = 32'd0;
`endif
    checks++;
    if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL stats: got hit=%0d miss=%0d, required hit=%0d miss=%0d",
               hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_top_index();
    mem_q.push_back('{we: 1'b0, addr: 32'hF0, wline: 128'h0, rline: LINE_C});
    access(1'b0, 32'hFC, 32'h0, 32'hCCCC_0003, 2 + LAT, "top_index_miss");
    access(1'b0, 32'hF4, 32'h0, 32'hCCCC_0001, 0, "top_index_hit");
    access(1'b0, 32'h148, 32'h0, 32'hBBBB_0002, 0, "other_line_kept");
    check_mem_q_empty("top_index");
  endtask

  task automatic test_reset_mid();
    mem_q.push_back('{we: 1'b0, addr: 32'h200, wline: 128'h0, rline: LINE_D});
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h200;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL alloc_entry: got req=%0b we=%0b stall=%0b, required 1 0 1", mem_req, mem_we, cpu_stall);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_q.push_back('{we: 1'b0, addr: 32'h40, wline: 128'h0, rline: LINE_A});
    access(1'b0, 32'h44, 32'h0, 32'h2222_2222, 2 + LAT, "post_reset_miss");
    check_mem_q_empty("reset_mid");
  endtask

  task automatic test_back_to_back();
    access(1'b0, 32'h40, 32'h0, 32'h1111_1111, 0, "b2b_w0");
    access(1'b1, 32'h4C, 32'h1234_5678, 32'h0, 0, "b2b_store");
    access(1'b0, 32'h4C, 32'h0, 32'h1234_5678, 0, "b2b_w3");
    access(1'b0, 32'h48, 32'h0, 32'h3333_3333, 0, "b2b_w2");
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_clean_miss();
    test_hit();
    test_store_load();
    test_dirty_miss();
    test_stats();
    test_top_index();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
